// File: rtl/count_pkg.sv
// count_pkg: shared types for the count_step block.
//   mode_e  - counting mode (WRAP, SAT, ONESHOT); encoding 2'b11 is reserved
//   state_e - control state (RUN, DONE)
//   decode_mode - maps the raw 2-bit mode input onto mode_e, reserved -> WRAP
package count_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'b00,
        SAT     = 2'b01,
        ONESHOT = 2'b10
    } mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    // The reserved encoding folds onto WRAP so the datapath never sees an
    // out-of-enum value.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = SAT;
            2'b10:   m = ONESHOT;
            default: m = WRAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/count_step_calc.sv
// count_step_calc: purely combinational next-value logic for count_step.
// Ports:
//   count      - current registered count
//   up         - direction, 1 = up, 0 = down
//   step       - unsigned increment
//   mode       - decoded counting mode
//   load_val   - raw load value
//   next_count - count value for an enabled update
//   tc_hit     - the enabled update qualifies for a terminal-count pulse
//   stop       - the enabled update ends a ONESHOT run
//   load_count - load_val clamped to MODULUS-1
module count_step_calc
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned STEP_W  = 2,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  next_count,
    output logic              tc_hit,
    output logic              stop,
    output logic [WIDTH-1:0]  load_count
);

    // Wide enough that count+step and count+MODULUS never overflow.
    localparam int unsigned EW = WIDTH + STEP_W + 1;
    localparam logic [EW-1:0] MOD_X = EW'(MODULUS);
    localparam logic [EW-1:0] MAX_X = EW'(MODULUS - 1);

    logic [EW-1:0] cnt_x;
    logic [EW-1:0] step_x;
    logic [EW-1:0] sum_x;
    logic [EW-1:0] diff_x;
    logic [EW-1:0] lim_x;
    logic [EW-1:0] next_x;
    logic [EW-1:0] ld_x;
    logic          ovf;
    logic          unf;
    logic          at_lim;
    logic          reach_lim;
    logic          unused_hi;

    always_comb begin
        cnt_x  = EW'(count);
        step_x = EW'(step);
        sum_x  = cnt_x + step_x;
        // Only used when no underflow, so the modular result is never seen.
        diff_x = cnt_x - step_x;
        ovf    = up & (sum_x >= MOD_X);
        unf    = ~up & (cnt_x < step_x);
        lim_x  = up ? MAX_X : '0;

        unique case (mode)
            SAT, ONESHOT: begin
                if (up) next_x = ovf ? MAX_X : sum_x;
                else    next_x = unf ? '0 : diff_x;
            end
            default: begin
                if (up) next_x = ovf ? (sum_x - MOD_X) : sum_x;
                else    next_x = unf ? (cnt_x + MOD_X - step_x) : diff_x;
            end
        endcase

        at_lim    = (cnt_x == lim_x);
        reach_lim = (next_x == lim_x);

        // SAT only pulses on the transition onto the limit, never while parked
        // there. ONESHOT terminates on any clamp or arrival at the limit; a
        // zero step is a no-op in every mode.
        tc_hit = 1'b0;
        stop   = 1'b0;
        unique case (mode)
            SAT: begin
                tc_hit = reach_lim & ~at_lim;
            end
            ONESHOT: begin
                tc_hit = (step != '0) & (ovf | unf | reach_lim);
                stop   = tc_hit;
            end
            default: begin
                tc_hit = ovf | unf;
            end
        endcase

        next_count = next_x[WIDTH-1:0];

        ld_x       = EW'(load_val);
        if (ld_x > MAX_X) ld_x = MAX_X;
        load_count = ld_x[WIDTH-1:0];
    end

    // Upper bits are always zero by construction.
    assign unused_hi = ^{next_x[EW-1:WIDTH], ld_x[EW-1:WIDTH]};

endmodule

// File: rtl/count_step.sv
// count_step: configurable up/down step counter with WRAP, SAT and ONESHOT
// modes. Holds only the state registers and the RUN/DONE FSM; all next-value
// arithmetic lives in count_step_calc.
// Ports:
//   clk      - clock, rising edge active
//   rst      - asynchronous active-low reset
//   clr      - synchronous clear (highest priority)
//   load     - synchronous load of load_val (clamped to MODULUS-1)
//   load_val - load value
//   en       - count enable
//   up       - direction, 1 = up, 0 = down
//   step     - unsigned increment per enabled cycle, must be < MODULUS
//   mode     - 00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (WRAP)
//   count    - registered count value
//   tc       - registered one-cycle terminal-count pulse
//   done     - registered, high while stopped in ONESHOT
module count_step
    import count_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned STEP_W  = 2,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              done
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             done_q;

    mode_e            mode_dec;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_count;
    logic             tc_hit;
    logic             stop;

    assign mode_dec = decode_mode(mode);

    count_step_calc #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .MODULUS (MODULUS)
    ) u_calc (
        .count      (count_q),
        .up         (up),
        .step       (step),
        .mode       (mode_dec),
        .load_val   (load_val),
        .next_count (next_count),
        .tc_hit     (tc_hit),
        .stop       (stop),
        .load_count (load_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (clr) begin
            state_q <= RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (load) begin
            state_q <= RUN;
            count_q <= load_count;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // tc is a single-cycle pulse: cleared unless this edge qualifies.
            tc_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (en) begin
                        count_q <= next_count;
                        tc_q    <= tc_hit;
                        if (stop) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE: all counting inputs ignored until clr or load.
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

    // A step of MODULUS or more has no defined meaning for this counter.
    step_range_a : assert property (
        @(posedge clk) disable iff (!rst) en |-> (32'(step) < MODULUS)
    ) else $error("count_step: step %0d >= MODULUS %0d", step, MODULUS);

endmodule
